mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max wait cycles for DMem_ack before abort (range 1-255).
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-003 Clk  in  1  rising-edge clock.
REQ-004 Reset  in  1  synchronous active-high reset.
REQ-005 EX_Mem_wr_en, EX_Mem_rd_en  in  1 each  store / load request from execute stage.
REQ-006 EX_Mem_op  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 EX_ALU_result  in  32  effective address, or result for non-memory instructions.
REQ-008 EX_Rs2_data  in  32  store data.
REQ-009 EX_MemToReg, EX_RegFile_wr_en  in  1 each; EX_Rd_addr  in  5.
REQ-010 DMem_req, DMem_we  out  1 each; DMem_addr  out  32 (word-aligned, [1:0]=00); DMem_wdata  out  32; DMem_be  out  4.
REQ-011 DMem_ack  in  1; DMem_rdata  in  32 (valid when DMem_ack=1).
REQ-012 MEM_Stall  out  1  holds execute stage and upstream stages.
REQ-013 MEM_RegFile_wr_en  out  1; MEM_Rd_addr  out  5; MEM_Rd_data  out  32  writeback/forwarding data.
REQ-014 MEM_Misaligned, MEM_Bus_err  out  1 each  one-cycle exception pulses.

Function
REQ-015 Access = (EX_Mem_rd_en|EX_Mem_wr_en) & aligned; aligned: B always, H needs addr[0]=0, W needs addr[1:0]=00; rd_en and wr_en both set is treated as store.
REQ-016 DMem_req SHALL be combinational = Access & !Reset & state in {IDLE, BUSY}; DMem_we = EX_Mem_wr_en; DMem_addr = {EX_ALU_result[31:2],2'b00}.
REQ-017 Stores: B -> be=0001<<addr[1:0], wdata=byte replicated x4; H -> be=0011<<addr[1:0], wdata=half replicated x2; W -> be=1111, wdata=Rs2.
REQ-018 MEM_Stall SHALL be combinational = DMem_req & !DMem_ack & !timeout_hit; execute stage holds all EX_* inputs stable while MEM_Stall=1.
REQ-019 FSM states IDLE, BUSY. IDLE: Access & !ack -> BUSY, wait counter=1; Access & ack -> complete, stay IDLE.
REQ-020 BUSY: ack -> complete, IDLE; else counter==MEM_TIMEOUT -> abort, IDLE; else counter+1.
REQ-021 Complete (registered, next edge): MEM_Rd_addr=EX_Rd_addr, MEM_RegFile_wr_en=EX_RegFile_wr_en, MEM_Rd_data=formatted load data if EX_MemToReg else EX_ALU_result.
REQ-022 Load format: lane = addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-023 Non-memory instruction: 1-cycle pass-through, no req, no stall.
REQ-024 Misaligned access: no DMem_req, no stall; next edge MEM_Misaligned=1 for one cycle, MEM_RegFile_wr_en=0.
REQ-025 Abort (timeout): stall released the same cycle; next edge MEM_Bus_err=1 for one cycle, MEM_RegFile_wr_en=0; a late ack arriving in IDLE with no Access SHALL be ignored.
REQ-026 Ack in zero-wait cycle: zero stall cycles; load latency = 1 + wait cycles.
REQ-027 Stores SHALL never assert MEM_RegFile_wr_en regardless of EX_RegFile_wr_en.

Reset
REQ-028 Reset SHALL force state=IDLE, counter=0, MEM_RegFile_wr_en=0, MEM_Rd_addr=0, MEM_Rd_data=0, MEM_Misaligned=0, MEM_Bus_err=0.
REQ-029 Reset asserted in BUSY SHALL drop DMem_req and MEM_Stall combinationally and abandon the access without error pulse.

Verification
REQ-030 LB addr=0x103, rdata=0x80FF_FF11, ack 2 cycles late -> MEM_Stall high 2 cycles, then MEM_Rd_data=0xFFFF_FF80, wr_en=1.
REQ-031 SH addr=0x102, Rs2=0x0000_ABCD, zero-wait ack -> be=1100, wdata=0xABCD_ABCD, no stall, MEM_RegFile_wr_en=0.
REQ-032 LW addr=0x101 -> no DMem_req, MEM_Misaligned pulse, MEM_RegFile_wr_en=0.
REQ-033 LW, ack never arrives, MEM_TIMEOUT=3 -> stall 3 cycles, MEM_Bus_err pulse, no writeback; late ack ignored.
REQ-034 ADD result 0x1234 to x5 -> next cycle MEM_Rd_data=0x1234, MEM_Rd_addr=5, no req.
REQ-035 Reset raised in BUSY -> req/stall drop same cycle, all outputs 0 next edge, no error pulse.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I memory-access pipeline stage with wait-state handling and a bus timeout.
// Ports:
//   Clk, Reset                     - rising-edge clock, synchronous active-high reset
//   EX_Mem_wr_en / EX_Mem_rd_en    - store / load request from execute
//   EX_Mem_op                      - funct3 access size and signedness
//   EX_ALU_result, EX_Rs2_data     - effective address (or ALU result), store data
//   EX_MemToReg, EX_RegFile_wr_en, EX_Rd_addr - writeback control from execute
//   DMem_*                         - data memory request/response bus
//   MEM_Stall                      - holds execute and upstream stages
//   MEM_RegFile_wr_en, MEM_Rd_addr, MEM_Rd_data - registered writeback/forwarding
//   MEM_Misaligned, MEM_Bus_err    - one-cycle exception pulses
module mem_access_stage #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        EX_Mem_wr_en,
    input  logic        EX_Mem_rd_en,
    input  logic [2:0]  EX_Mem_op,
    input  logic [31:0] EX_ALU_result,
    input  logic [31:0] EX_Rs2_data,
    input  logic        EX_MemToReg,
    input  logic        EX_RegFile_wr_en,
    input  logic [4:0]  EX_Rd_addr,
    output logic        DMem_req,
    output logic        DMem_we,
    output logic [31:0] DMem_addr,
    output logic [31:0] DMem_wdata,
    output logic [3:0]  DMem_be,
    input  logic        DMem_ack,
    input  logic [31:0] DMem_rdata,
    output logic        MEM_Stall,
    output logic        MEM_RegFile_wr_en,
    output logic [4:0]  MEM_Rd_addr,
    output logic [31:0] MEM_Rd_data,
    output logic        MEM_Misaligned,
    output logic        MEM_Bus_err
);
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_wr_en;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd_data;
    logic        r_mis;
    logic        r_berr;
    logic [1:0]  w_lane;
    logic        w_mem;
    logic        w_aligned;
    logic        w_access;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    always_comb begin
        w_lane     = EX_ALU_result[1:0];
        w_mem      = EX_Mem_rd_en | EX_Mem_wr_en;
        w_aligned  = (EX_Mem_op[1:0] == 2'b00) ? 1'b1 :
                     (EX_Mem_op[1:0] == 2'b01) ? !w_lane[0] : (w_lane == 2'b00);
        w_access   = w_mem & w_aligned;
        DMem_req   = w_access & !Reset;
        DMem_we    = EX_Mem_wr_en;
        DMem_addr  = {EX_ALU_result[31:2], 2'b00};
        DMem_be    = (EX_Mem_op[1:0] == 2'b00) ? 4'b0001 << w_lane :
                     (EX_Mem_op[1:0] == 2'b01) ? 4'b0011 << w_lane : 4'b1111;
        DMem_wdata = (EX_Mem_op[1:0] == 2'b00) ? {4{EX_Rs2_data[7:0]}} :
                     (EX_Mem_op[1:0] == 2'b01) ? {2{EX_Rs2_data[15:0]}} : EX_Rs2_data;
        // The last allowed wait cycle releases the stall even without an ack.
        w_timeout  = (r_state == BUSY) && (r_cnt == TIMEOUT) && !DMem_ack;
        MEM_Stall  = DMem_req & !DMem_ack & !w_timeout;
        w_done     = w_access & DMem_ack;
        w_shift    = DMem_rdata >> {w_lane, 3'b000};
        w_load     = (EX_Mem_op == 3'b000) ? {{24{w_shift[7]}}, w_shift[7:0]} :
                     (EX_Mem_op == 3'b001) ? {{16{w_shift[15]}}, w_shift[15:0]} :
                     (EX_Mem_op == 3'b100) ? {24'd0, w_shift[7:0]} :
                     (EX_Mem_op == 3'b101) ? {16'd0, w_shift[15:0]} : DMem_rdata;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_mis     <= 1'b0;
            r_berr    <= 1'b0;
        end else begin
            r_mis   <= w_mem & !w_aligned;
            r_berr  <= w_access & w_timeout;
            // Any stalled cycle is a wait cycle: the first one moves IDLE->BUSY with count 1.
            r_state <= MEM_Stall ? BUSY : IDLE;
            r_cnt   <= MEM_Stall ? r_cnt + 8'd1 : '0;
            if (!w_mem || w_done) begin
                r_wr_en   <= EX_RegFile_wr_en & !EX_Mem_wr_en;
                r_rd_addr <= EX_Rd_addr;
                r_rd_data <= EX_MemToReg ? w_load : EX_ALU_result;
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end
    assign MEM_RegFile_wr_en = r_wr_en;
    assign MEM_Rd_addr       = r_rd_addr;
    assign MEM_Rd_data       = r_rd_data;
    assign MEM_Misaligned    = r_mis;
    assign MEM_Bus_err       = r_berr;
endmodule
